// File: rtl/board_clock_pkg.sv
// Shared encodings for the board clock monitor and its VIO/LED decode logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package board_clock_pkg;

  // Health state as seen on the state output and by the LED/VIO decoders.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } clk_state_e;

  // Width of the saturating out-of-window sample counter.
  localparam int BAD_W = 16;

endpackage

// File: rtl/board_clock_monitor.sv
// Judges per-ms testclk counts against NOM +/- TOL and runs a lock/fault FSM with hysteresis plus sticky stats.
// Latency: every effect of count_valid / clear on cycle N is visible on cycle N+1 (all outputs registered).
// Backpressure: none; every count_valid strobe is evaluated, back-to-back strobes allowed.
//
// Ports:
//   sysclk, rst_n (async, active-low)       clock and reset
//   count_in/count_valid                    per-ms count and its one-cycle strobe
//   clear                                   clears min/max/bad_total/err_sticky
//   state, clk_ok, dead                     health verdict
//   err_sticky, min_count, max_count, bad_total  checkout statistics
module board_clock_monitor
  import board_clock_pkg::*;
#(
  parameter int COUNT_WIDTH = 48,
  parameter int NOM_COUNT   = 100000,
  parameter int TOL_COUNT   = 100,
  parameter int LOCK_COUNT  = 4,
  parameter int FAIL_COUNT  = 2
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   count_valid,
  input  logic                   clear,
  output logic [1:0]             state,
  output logic                   clk_ok,
  output logic                   dead,
  output logic                   err_sticky,
  output logic [COUNT_WIDTH-1:0] min_count,
  output logic [COUNT_WIDTH-1:0] max_count,
  output logic [BAD_W-1:0]       bad_total
);

  // Window bounds carry one extra bit so NOM+TOL cannot wrap.
  localparam int CW1 = COUNT_WIDTH + 1;
  localparam logic [CW1-1:0] HI_B = CW1'(NOM_COUNT) + CW1'(TOL_COUNT);
  localparam logic [CW1-1:0] LO_B = (TOL_COUNT > NOM_COUNT) ? '0
                                  : CW1'(NOM_COUNT) - CW1'(TOL_COUNT);

  localparam int MAX_RUN = (LOCK_COUNT > FAIL_COUNT) ? LOCK_COUNT : FAIL_COUNT;
  localparam int RUN_W   = $clog2(MAX_RUN + 1);
  // Runs are compared against "target - 1" so the counter never holds the target itself.
  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0] FAIL_LAST = RUN_W'(FAIL_COUNT - 1);

  clk_state_e             state_q, state_d;
  logic [RUN_W-1:0]       streak_q, streak_d;
  logic [RUN_W-1:0]       miss_q, miss_d;
  logic                   err_q, err_d;
  logic                   dead_q, dead_d;
  logic [COUNT_WIDTH-1:0] min_q, min_d;
  logic [COUNT_WIDTH-1:0] max_q, max_d;
  logic [BAD_W-1:0]       bad_q, bad_d;

  logic                   in_win;
  logic [COUNT_WIDTH-1:0] min_base, max_base;
  logic [BAD_W-1:0]       bad_base;

  assign in_win = ({1'b0, count_in} >= LO_B) && ({1'b0, count_in} <= HI_B);

  // A clear coinciding with a sample restarts the statistics from that sample.
  assign min_base = clear ? {COUNT_WIDTH{1'b1}} : min_q;
  assign max_base = clear ? '0 : max_q;
  assign bad_base = clear ? '0 : bad_q;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    miss_d   = miss_q;
    err_d    = clear ? 1'b0 : err_q;
    dead_d   = dead_q;
    min_d    = min_base;
    max_d    = max_base;
    bad_d    = bad_base;

    if (count_valid) begin
      dead_d = (count_in == '0);
      if (count_in < min_base) min_d = count_in;
      if (count_in > max_base) max_d = count_in;
      if (!in_win && (bad_base != {BAD_W{1'b1}})) bad_d = bad_base + BAD_W'(1);

      unique case (state_q)
        ST_LOCKED: begin
          if (in_win) begin
            miss_d = '0;
          end else if (miss_q == FAIL_LAST) begin
            state_d  = ST_FAULT;
            miss_d   = '0;
            streak_d = '0;
            err_d    = 1'b1;  // wins over a simultaneous clear
          end else begin
            miss_d = miss_q + RUN_W'(1);
          end
        end
        default: begin
          // IDLE evaluates its first sample exactly like ACQUIRE.
          if (state_q == ST_IDLE) state_d = ST_ACQUIRE;
          if (!in_win) begin
            streak_d = '0;
          end else if (streak_q == LOCK_LAST) begin
            state_d  = ST_LOCKED;
            streak_d = '0;
            miss_d   = '0;
          end else begin
            streak_d = streak_q + RUN_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      streak_q <= '0;
      miss_q   <= '0;
      err_q    <= 1'b0;
      dead_q   <= 1'b0;
      min_q    <= {COUNT_WIDTH{1'b1}};
      max_q    <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      dead_q   <= dead_d;
      min_q    <= min_d;
      max_q    <= max_d;
      bad_q    <= bad_d;
    end
  end

  assign state      = state_q;
  assign clk_ok     = (state_q == ST_LOCKED);
  assign dead       = dead_q;
  assign err_sticky = err_q;
  assign min_count  = min_q;
  assign max_count  = max_q;
  assign bad_total  = bad_q;

endmodule

// File: tb/tb_board_clock_monitor.sv
// Bench for board_clock_monitor: directed scenarios with literal pins plus randomized strobes.
// Latency: model is advanced 1 time unit after each rising edge; DUT compared on every falling edge.
// Backpressure: n/a.
module tb_board_clock_monitor;

  localparam int CW = 48;
  localparam logic [CW-1:0] ALL1 = {CW{1'b1}};
  localparam longint NOM = 100000;
  localparam longint TOL = 100;
  localparam int LOCKN = 4;
  localparam int FAILN = 2;

  logic          sysclk = 1'b0;
  logic          rst_n  = 1'b0;
  logic [CW-1:0] count_in = '0;
  logic          count_valid = 1'b0;
  logic          clear = 1'b0;
  logic [1:0]    state;
  logic          clk_ok, dead, err_sticky;
  logic [CW-1:0] min_count, max_count;
  logic [15:0]   bad_total;

  board_clock_monitor dut (
    .sysclk(sysclk), .rst_n(rst_n), .count_in(count_in), .count_valid(count_valid),
    .clear(clear), .state(state), .clk_ok(clk_ok), .dead(dead), .err_sticky(err_sticky),
    .min_count(min_count), .max_count(max_count), .bad_total(bad_total)
  );

  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Reference model: plain integers describing the rules, not the RTL structure.
  int            m_state;   // 0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 FAULT
  int            m_streak, m_miss, m_bad;
  bit            m_err, m_dead;
  logic [CW-1:0] m_min, m_max;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_streak = 0; m_miss = 0; m_bad = 0;
    m_err = 0; m_dead = 0; m_min = ALL1; m_max = '0;
  endtask

  task automatic model_step(input bit v, input logic [CW-1:0] c, input bit clr);
    bit inw;
    longint lo;
    if (clr) begin
      m_min = ALL1; m_max = '0; m_bad = 0; m_err = 0;
    end
    if (v) begin
      lo  = (TOL > NOM) ? 0 : NOM - TOL;
      inw = (c >= CW'(lo)) && (c <= CW'(NOM + TOL));
      m_dead = (c == 0);
      if (c < m_min) m_min = c;
      if (c > m_max) m_max = c;
      if (!inw && m_bad < 65535) m_bad++;
      if (m_state == 2) begin
        if (inw) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == FAILN) begin
            m_state = 3; m_miss = 0; m_streak = 0; m_err = 1;
          end
        end
      end else begin
        if (m_state == 0) m_state = 1;
        if (!inw) m_streak = 0;
        else begin
          m_streak++;
          if (m_streak == LOCKN) begin
            m_state = 2; m_streak = 0; m_miss = 0;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, then advance the model past the clock edge that samples them.
  task automatic cyc(input bit v, input logic [CW-1:0] c, input bit clr);
    count_valid = v;
    count_in    = c;
    clear       = clr;
    @(posedge sysclk);
    #1;
    model_step(v, c, clr);
    count_valid = 1'b0;
    clear       = 1'b0;
  endtask

  // Single compare process against the model.
  always @(negedge sysclk) begin
    if (chk_on) begin
      chk("state", 64'(state), 64'(m_state));
      chk("clk_ok", 64'(clk_ok), 64'(m_state == 2));
      chk("dead", 64'(dead), 64'(m_dead));
      chk("err_sticky", 64'(err_sticky), 64'(m_err));
      chk("min_count", 64'(min_count), 64'(m_min));
      chk("max_count", 64'(max_count), 64'(m_max));
      chk("bad_total", 64'(bad_total), 64'(m_bad));
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [CW-1:0] rc;
  int r;

  initial begin
    model_reset();
    apply_reset();
    chk_on = 1'b1;

    // Reset state pinned to literals.
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_min", 64'(min_count), 64'hFFFF_FFFF_FFFF);
    chk("rst_max", 64'(max_count), 64'd0);

    // Scenario 1: acquire lock.
    for (int i = 0; i < 4; i++) begin
      cyc(1, CW'(100000), 0);
      chk("s1_state", 64'(state), (i < 3) ? 64'd1 : 64'd2);
    end
    chk("s1_clk_ok", 64'(clk_ok), 64'd1);
    chk("s1_min", 64'(min_count), 64'd100000);
    chk("s1_max", 64'(max_count), 64'd100000);
    chk("s1_bad", 64'(bad_total), 64'd0);

    // Scenario 2: broken miss run, then fault.
    cyc(1, CW'(100101), 0);
    cyc(1, CW'(100000), 0);
    cyc(1, CW'(100101), 0);
    chk("s2_stay_locked", 64'(state), 64'd2);
    chk("s2_bad", 64'(bad_total), 64'd2);
    cyc(1, CW'(100101), 0);
    chk("s2_fault", 64'(state), 64'd3);
    chk("s2_err", 64'(err_sticky), 64'd1);
    chk("s2_clk_ok", 64'(clk_ok), 64'd0);

    // Scenario 3: window boundaries and dead sample.
    cyc(1, CW'(99900), 0);
    chk("s3_lo_in", 64'(bad_total), 64'd3);
    cyc(1, CW'(100100), 0);
    chk("s3_hi_in", 64'(bad_total), 64'd3);
    cyc(1, CW'(99899), 0);
    chk("s3_lo_out", 64'(bad_total), 64'd4);
    cyc(1, CW'(100101), 0);
    chk("s3_hi_out", 64'(bad_total), 64'd5);
    cyc(1, CW'(0), 0);
    chk("s3_dead", 64'(dead), 64'd1);
    chk("s3_bad0", 64'(bad_total), 64'd6);
    chk("s3_min0", 64'(min_count), 64'd0);

    // Scenario 4: relock from FAULT, then clear.
    for (int i = 0; i < 4; i++) cyc(1, CW'(100050), 0);
    chk("s4_relock", 64'(state), 64'd2);
    chk("s4_err_held", 64'(err_sticky), 64'd1);
    cyc(0, CW'(100050), 1);
    chk("s4_err_clr", 64'(err_sticky), 64'd0);
    chk("s4_bad_clr", 64'(bad_total), 64'd0);
    chk("s4_min_clr", 64'(min_count), 64'hFFFF_FFFF_FFFF);
    chk("s4_max_clr", 64'(max_count), 64'd0);
    chk("s4_state", 64'(state), 64'd2);

    // Scenario 5: clear with sample, then saturation.
    cyc(1, CW'(99950), 1);
    chk("s5_min", 64'(min_count), 64'd99950);
    chk("s5_max", 64'(max_count), 64'd99950);
    chk("s5_bad", 64'(bad_total), 64'd0);
    for (int i = 0; i < 70000; i++) cyc(1, CW'(0), 0);
    chk("s5_sat", 64'(bad_total), 64'hFFFF);

    // Randomized traffic from a fresh reset.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       rc = '0;
        1, 2, 3, 4: rc = CW'($urandom_range(99898, 100102));
        5, 6, 7: rc = CW'(100000);
        8:       rc = {16'($urandom), 32'($urandom)};
        default: rc = CW'($urandom_range(99000, 101000));
      endcase
      cyc($urandom_range(0, 9) < 7, rc, $urandom_range(0, 31) == 0);
    end

    // Scenario 6: async reset mid-ACQUIRE.
    apply_reset();
    for (int i = 0; i < 3; i++) cyc(1, CW'(100000), 0);
    chk("s6_acq", 64'(state), 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_state", 64'(state), 64'd0);
    chk("s6_rst_max", 64'(max_count), 64'd0);
    chk("s6_rst_min", 64'(min_count), 64'hFFFF_FFFF_FFFF);
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    cyc(1, CW'(100000), 0);
    chk("s6_after", 64'(state), 64'd1);
    chk("s6_clk_ok", 64'(clk_ok), 64'd0);

    @(posedge sysclk);
    #1;
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_clock_monitor.md
# board_clock_monitor

Judges the per-millisecond testclk counts produced by the board clock counter on sysclk and turns them into a health verdict. Each count is checked against a nominal value ± tolerance, and a lock/fault state machine is advanced with hysteresis. The block also keeps sticky error, min/max and bad-sample statistics, which feed the checkout VIO and board status LEDs. One instance sits downstream of each clock counter.

## Interface
- COUNT_WIDTH, 48: width of incoming count and min/max outputs.
- NOM_COUNT, 100000: expected testclk cycles per millisecond tick.
- TOL_COUNT, 100: allowed deviation, inclusive, in counts.
- LOCK_COUNT, 4: consecutive in-window samples needed to enter LOCKED (≥1).
- FAIL_COUNT, 2: consecutive out-of-window samples in LOCKED needed to enter FAULT (≥1).

Ports:
- sysclk  in  1  sole clock.
- rst_n  in  1  reset; asynchronous, active-low.
- count_in  in  COUNT_WIDTH  latest per-ms testclk count; held stable while count_valid is high.
- count_valid  in  1  one-cycle strobe; a new count_in is present.
- clear  in  1  one-cycle pulse; clears statistics and err_sticky.
- state  out  2  0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 FAULT.
- clk_ok  out  1  high iff state == LOCKED.
- dead  out  1  last evaluated sample was exactly 0.
- err_sticky  out  1  set on every LOCKED→FAULT transition; cleared only by clear or reset.
- min_count  out  COUNT_WIDTH  smallest sample since reset/clear.
- max_count  out  COUNT_WIDTH  largest sample since reset/clear.
- bad_total  out  16  out-of-window samples since reset/clear; saturates at 0xFFFF.

## Operation
- Window test: in_win = (count_in ≥ LO) && (count_in ≤ HI).
  - HI = NOM_COUNT + TOL_COUNT.
  - LO = NOM_COUNT − TOL_COUNT, clamped to 0 when TOL_COUNT > NOM_COUNT.
  - Bounds are computed at COUNT_WIDTH+1 bits, so there is no wrap.
- Internal counters: streak (in-window run) and miss (out-of-window run), each wide enough for the maximum of LOCK_COUNT/FAIL_COUNT.
- All evaluation happens only on cycles with count_valid=1. Without count_valid, nothing changes except the clear effects.
- IDLE:
  - First valid sample moves to ACQUIRE and is evaluated exactly as in ACQUIRE.
  - If LOCK_COUNT=1 and that sample is in-window, the next state is LOCKED directly.
- ACQUIRE and FAULT:
  - In-window: streak+1. Reaching LOCK_COUNT → LOCKED, streak=0, miss=0.
  - Out-of-window: streak=0, state unchanged.
- LOCKED:
  - In-window: miss=0.
  - Out-of-window: miss+1. Reaching FAIL_COUNT → FAULT, miss=0, streak=0, err_sticky=1.
- Statistics, per valid sample:
  - min_count = min(min_count, count_in).
  - max_count = max(max_count, count_in).
  - bad_total increments (saturating) when the sample is out-of-window.
  - dead = (count_in == 0).
- clear:
  - Sets min_count to all-ones, max_count to 0, bad_total to 0, err_sticky to 0.
  - Does not change state, streak, miss or dead.
- clear together with count_valid in the same cycle:
  - Statistics restart from that sample: min=max=count_in; bad_total = 0 or 1.
  - err_sticky ends at 1 only if that same sample causes LOCKED→FAULT.
- A zero sample is an ordinary out-of-window sample (unless LO=0) and also sets dead.

## Timing
- Reset values: state=IDLE, clk_ok=0, dead=0, err_sticky=0, min_count=all-ones, max_count=0, bad_total=0, streak=0, miss=0.
- All outputs are registered. Every effect of a count_valid or clear on cycle N is visible on cycle N+1; there is no other latency.
- clk_ok is decoded from the state register, so it is coincident with state.
- count_valid may occur on consecutive cycles; every strobe is evaluated.
- rst_n assertion mid-run returns everything to reset values immediately (asynchronously). Deassertion must be synchronised externally to sysclk.

## Structure
- Package board_clock_pkg holds the state encoding constants (IDLE/ACQUIRE/LOCKED/FAULT) and the bad_total width, shared with VIO/LED decode logic.
- No sub-module. The window comparator, state register, run counters and statistics registers all live in one module of roughly 150–250 lines.

## Test plan
All scenarios use the defaults (NOM 100000, TOL 100, LOCK 4, FAIL 2).
1. Reset, then four valids at 100000 → state goes 1,1,1,2 one cycle after each strobe; clk_ok=1 after the 4th; min=max=100000; bad_total=0.
2. LOCKED, then 100101, 100000, 100101 → stays LOCKED (the miss run is broken); bad_total=2. A further 100101 → FAULT, err_sticky=1, clk_ok=0.
3. Boundary check: samples 99900 and 100100 are in-window; 99899 and 100101 are out. Sample 0 → dead=1, bad_total+1, min_count=0.
4. FAULT, then four samples at 100050 → LOCKED with err_sticky still 1. A clear pulse → err_sticky=0, bad_total=0, min=all-ones, max=0, state stays LOCKED.
5. clear and count_valid in the same cycle with count 99950 → next cycle min=max=99950, bad_total=0. 70000 strobes of 0 → bad_total saturates at 0xFFFF.
6. rst_n pulled low mid-ACQUIRE (streak 3) → all outputs at reset values immediately. After release, the first sample at 100000 gives ACQUIRE, not LOCKED.
